// File: rtl/lockstep_compare_ctrl_pkg.sv
// Shared types and constants for the lockstep compare controller.
// State encodings match the numbering the safety island decodes from state_o.
package lockstep_compare_ctrl_pkg;

  localparam int LOCKSTEP_DELAY = 2;
  localparam logic [1:0] WARMUP_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // True when one more mismatch makes the run of consecutive mismatches permanent.
  function automatic logic reaches_thresh(input logic [3:0] consec, input int thresh);
    return (int'(consec) + 1) >= thresh;
  endfunction

endpackage

// File: rtl/lockstep_compare_ctrl_delay_unit.sv
// Fixed-depth shift register that aligns the master bundle with the lagging checker core.
// Stages are deliberately unreset; the controller masks their contents during warm-up.
module delay_unit #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    stage[0] <= data;
    for (int i = 1; i < DEPTH; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/lockstep_compare_ctrl.sv
// Lockstep master/checker comparator: aligns the master bundle, classifies mismatches
// as transient (recover) or permanent (fault), and reports status to the safety island.
module lockstep_compare_ctrl
  import lockstep_compare_ctrl_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 32,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int PERSIST_THRESH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     master_valid_i,
  input  logic [OPERAND_WIDTH-1:0] master_i,
  input  logic                     checker_valid_i,
  input  logic [OPERAND_WIDTH-1:0] checker_i,
  input  logic                     recover_ack_i,
  output logic                     mismatch_o,
  output logic                     irq_o,
  output logic                     recover_req_o,
  output logic                     fault_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [OPERAND_WIDTH-1:0] syndrome_o,
  output logic [2:0]               state_o
);

  logic [OPERAND_WIDTH:0]   d_word;
  logic                     d_valid;
  logic [OPERAND_WIDTH-1:0] d_data;

  delay_unit #(
    .WIDTH (OPERAND_WIDTH + 1),
    .DEPTH (LOCKSTEP_DELAY)
  ) u_delay (
    .clk     (clk),
    .data    ({master_valid_i, master_i}),
    .delayed (d_word)
  );

  assign d_valid = d_word[OPERAND_WIDTH];
  assign d_data  = d_word[OPERAND_WIDTH-1:0];

  state_t                   state;
  logic [1:0]               warm_cnt;
  logic [3:0]               consec_cnt;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic [OPERAND_WIDTH-1:0] syndrome;

  logic                     qualified;
  logic                     mismatch;
  logic [OPERAND_WIDTH-1:0] diff;

  // A cycle with neither side valid is idle traffic, not a compare.
  assign qualified = (state == ST_CHECK) && enable_i && (d_valid || checker_valid_i);
  assign diff      = d_data ^ checker_i;
  assign mismatch  = qualified && ((d_valid != checker_valid_i) || (diff != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      warm_cnt      <= '0;
      consec_cnt    <= '0;
      err_count     <= '0;
      syndrome      <= '0;
      mismatch_o    <= 1'b0;
      irq_o         <= 1'b0;
      recover_req_o <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      mismatch_o <= 1'b0;
      irq_o      <= 1'b0;
      if (clear_i) begin
        state         <= ST_IDLE;
        warm_cnt      <= '0;
        consec_cnt    <= '0;
        err_count     <= '0;
        syndrome      <= '0;
        recover_req_o <= 1'b0;
        fault_o       <= 1'b0;
      end else if (state == ST_FAULT) begin
        state <= ST_FAULT;
      end else if (!enable_i) begin
        state         <= ST_IDLE;
        recover_req_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_WARMUP;
            warm_cnt <= WARMUP_CYCLES;
          end
          ST_WARMUP: begin
            warm_cnt <= warm_cnt - 2'd1;
            if (warm_cnt == 2'd1) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (mismatch) begin
              mismatch_o <= 1'b1;
              irq_o      <= 1'b1;
              consec_cnt <= consec_cnt + 4'd1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (syndrome == '0) syndrome <= diff;
              if (reaches_thresh(consec_cnt, PERSIST_THRESH)) begin
                state   <= ST_FAULT;
                fault_o <= 1'b1;
              end else begin
                state         <= ST_RECOVER;
                recover_req_o <= 1'b1;
              end
            end else if (qualified) begin
              consec_cnt <= '0;
            end
          end
          ST_RECOVER: begin
            // Resync done: refill the delay line before comparing again.
            if (recover_ack_i) begin
              state         <= ST_WARMUP;
              warm_cnt      <= WARMUP_CYCLES;
              recover_req_o <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign err_count_o = err_count;
  assign syndrome_o  = syndrome;
  assign state_o     = state;

endmodule
